regfile_word_seq: RTL
=====================

Name: regfile_word_seq

Overview:
- Word-access sequencer placed directly upstream of the 16x16 byte-accessed register file.
- Accepts 16-bit register operations over a valid/ready request channel: READ, WRITE, MOVE and INC.
- Splits each operation into low-byte and high-byte register-file cycles through the file's addr/high_b/d_in/write_en/q_out port.
- Returns the result on a valid/ready response channel. Only this block drives the register-file port.

Parameters:
- ADDR_W, 4, register index width (16 registers)
- BYTE_W, 8, register-file byte lane width; the word is 2*BYTE_W bits

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request; high only in IDLE
- req_op  in  2  00 READ, 01 WRITE, 10 MOVE, 11 INC
- req_src  in  ADDR_W  source register (READ/MOVE/INC)
- req_dst  in  ADDR_W  destination register (WRITE/MOVE); INC writes back to req_src
- req_wdata  in  2*BYTE_W  write data (WRITE only)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  2*BYTE_W  READ: value read; WRITE: req_wdata; MOVE: value moved; INC: new value
- rsp_carry  out  1  INC only: 1 when the old value was 16'hFFFF; 0 for all other ops
- rf_addr  out  ADDR_W  register-file address
- rf_high_b  out  1  byte-lane select; 1 = bits [15:8]
- rf_d_in  out  BYTE_W  register-file write byte
- rf_write_en  out  1  register-file byte write strobe
- rf_q  in  BYTE_W  register-file combinational read byte

Behaviour:
- Reset (async, immediate):
  - state=IDLE; req_ready=1; rsp_valid=0; rsp_data=0; rsp_carry=0.
  - rf_addr=0; rf_high_b=0; rf_d_in=0; rf_write_en=0.
  - Latched op, operands and data_lo/data_hi cleared.
  - Reset mid-operation aborts with no further writes. A byte already written stays written unless the register file is reset too.
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, RESP.
- IDLE:
  - Request accepted on a rising edge with req_valid && req_ready; op, src, dst and wdata are latched.
  - Next state: READ/MOVE/INC -> RD_LO; WRITE -> WR_LO.
- RD_LO: rf_addr=src, rf_high_b=0, rf_write_en=0; rf_q captured into data_lo at the edge; -> RD_HI.
- RD_HI: rf_addr=src, rf_high_b=1; rf_q captured into data_hi; READ -> RESP, MOVE/INC -> WR_LO.
- WR_LO: rf_write_en=1, rf_high_b=0, rf_addr=dst (INC: src).
  - rf_d_in: WRITE wdata[7:0]; MOVE data_lo; INC (data_lo+1) mod 256.
  - -> WR_HI.
- WR_HI: rf_write_en=1, rf_high_b=1, same address.
  - rf_d_in: WRITE wdata[15:8]; MOVE data_hi; INC data_hi + (data_lo==8'hFF), mod 256.
  - -> RESP.
- rf_* outputs are decoded from state and latched operands. rf_write_en is high only in WR_LO and WR_HI (exactly 2 cycles per write op, 0 for READ). In IDLE and RESP the rf_* outputs take their reset values.
- RESP:
  - rsp_valid=1, with rsp_data and rsp_carry stable while rsp_valid && !rsp_ready.
  - rsp_valid && rsp_ready -> IDLE; rsp_valid drops on the next edge.
  - req_ready=0.
- Latency, acceptance edge to rsp_valid high: READ 3 edges, WRITE 3, MOVE 5, INC 5.
- Minimum request spacing = latency + 1 edges (the IDLE cycle). No overlap or pipelining.
- src==dst on MOVE is legal; it rewrites the same value.
- INC wraps 16'hFFFF -> 16'h0000 with rsp_carry=1.
- req_* inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.

Decomposition:
- Shared package holds:
  - op encodings: OP_READ=2'b00, OP_WRITE=2'b01, OP_MOVE=2'b10, OP_INC=2'b11;
  - the state enum;
  - REG_CNT=16 and WORD_W=16 constants.
- One natural sub-module, word_inc16: combinational 16-bit +1 returning the sum and carry. Everything else stays in the single FSM module.

Test Plan:
- After reset, WRITE dst=3 wdata=16'hA55A -> rf_write_en high exactly 2 cycles (lo byte 5A, then hi byte A5), rsp_valid at edge 3, rsp_data=A55A. Then READ src=3 -> rsp_data=A55A after 3 edges, rf_write_en never asserted.
- MOVE src=3 dst=7 with R3=16'h1234 -> R7=1234, R3 unchanged, rsp_data=1234, latency 5. MOVE src=7 dst=7 -> R7 still 1234.
- INC on R5=16'h00FF -> R5=0100, rsp_carry=0. INC on R5=16'hFFFF -> R5=0000, rsp_data=0000, rsp_carry=1.
- Response backpressure: hold rsp_ready=0 for 4 cycles in RESP -> rsp_valid, rsp_data and rsp_carry stable, req_ready=0, a new req_valid is ignored. Release rsp_ready -> IDLE next edge, then the new request is accepted.
- Reset mid-operation: assert rst_n=0 during WR_HI of a WRITE dst=2 -> rf_write_en drops immediately, rsp_valid never asserted. After release, state=IDLE and req_ready=1.
- Back-to-back: req_valid held high with 4 queued ops (WRITE, READ, INC, MOVE) and rsp_ready tied high -> each op accepted exactly once, in order, each spaced latency+1 edges.

Source files
------------

// File: rtl/regfile_word_seq_pkg.sv
// Shared encodings and FSM state type for the word-access register-file sequencer.
package regfile_word_seq_pkg;

  localparam int unsigned REG_CNT = 16;
  localparam int unsigned WORD_W  = 16;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_MOVE  = 2'b10;
  localparam logic [1:0] OP_INC   = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StRdLo,
    StRdHi,
    StWrLo,
    StWrHi,
    StResp
  } state_e;

endpackage

// File: rtl/word_inc16.sv
// Combinational 16-bit increment; carry is set when the input was all ones.
module word_inc16
  import regfile_word_seq_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  output logic [WORD_W-1:0] sum,
  output logic              carry
);

  assign {carry, sum} = {1'b0, a} + {{WORD_W{1'b0}}, 1'b1};

endmodule

// File: rtl/regfile_word_seq.sv
// Splits 16-bit READ/WRITE/MOVE/INC requests into low/high byte cycles on a
// byte-wide register-file port and returns the word on a valid/ready response.
module regfile_word_seq
  import regfile_word_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned BYTE_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [ADDR_W-1:0]   req_src,
  input  logic [ADDR_W-1:0]   req_dst,
  input  logic [2*BYTE_W-1:0] req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*BYTE_W-1:0] rsp_data,
  output logic                rsp_carry,
  output logic [ADDR_W-1:0]   rf_addr,
  output logic                rf_high_b,
  output logic [BYTE_W-1:0]   rf_d_in,
  output logic                rf_write_en,
  input  logic [BYTE_W-1:0]   rf_q
);

  localparam int unsigned WordW = 2 * BYTE_W;

  state_e              state_q, state_d;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   src_q, dst_q;
  logic [WordW-1:0]    wdata_q;
  logic [BYTE_W-1:0]   data_lo_q, data_hi_q;

  logic                accept;
  logic [WORD_W-1:0]   inc_sum;
  logic                inc_carry;
  logic [WordW-1:0]    word_sel;
  logic [ADDR_W-1:0]   wr_addr;

  assign accept = req_valid && (state_q == StIdle);

  word_inc16 u_inc (
    .a     ({data_hi_q, data_lo_q}),
    .sum   (inc_sum),
    .carry (inc_carry)
  );

  // One word serves both as the value written back and as the response payload.
  always_comb begin
    unique case (op_q)
      OP_WRITE: word_sel = wdata_q;
      OP_INC:   word_sel = inc_sum;
      default:  word_sel = {data_hi_q, data_lo_q};
    endcase
  end

  assign wr_addr = (op_q == OP_INC) ? src_q : dst_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = (req_op == OP_WRITE) ? StWrLo : StRdLo;
        end
      end
      StRdLo: state_d = StRdHi;
      StRdHi: state_d = (op_q == OP_READ) ? StResp : StWrLo;
      StWrLo: state_d = StWrHi;
      StWrHi: state_d = StResp;
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_READ;
      src_q     <= '0;
      dst_q     <= '0;
      wdata_q   <= '0;
      data_lo_q <= '0;
      data_hi_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= req_op;
        src_q   <= req_src;
        dst_q   <= req_dst;
        wdata_q <= req_wdata;
      end
      if (state_q == StRdLo) begin
        data_lo_q <= rf_q;
      end
      if (state_q == StRdHi) begin
        data_hi_q <= rf_q;
      end
    end
  end

  always_comb begin
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_data    = '0;
    rsp_carry   = 1'b0;
    rf_addr     = '0;
    rf_high_b   = 1'b0;
    rf_d_in     = '0;
    rf_write_en = 1'b0;
    unique case (state_q)
      StIdle: req_ready = 1'b1;
      StRdLo: rf_addr = src_q;
      StRdHi: begin
        rf_addr   = src_q;
        rf_high_b = 1'b1;
      end
      StWrLo: begin
        rf_write_en = 1'b1;
        rf_addr     = wr_addr;
        rf_d_in     = word_sel[BYTE_W-1:0];
      end
      StWrHi: begin
        rf_write_en = 1'b1;
        rf_addr     = wr_addr;
        rf_high_b   = 1'b1;
        rf_d_in     = word_sel[WordW-1:BYTE_W];
      end
      StResp: begin
        rsp_valid = 1'b1;
        rsp_data  = word_sel;
        rsp_carry = (op_q == OP_INC) && inc_carry;
      end
      default: ;
    endcase
  end

endmodule
